// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage types and constants; opcode values are shared with maindec.
package fetch_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
    localparam logic [15:0] INSTR_NOP = 16'h0000;
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 13;
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_BNE   = 3'b101;
    localparam logic [2:0] OP_J     = 3'b110;
    localparam logic [2:0] OP_JAL   = 3'b111;
endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register; flush beats load, otherwise hold. pcplus is kept on flush.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         flush,
    input  logic [n-1:0] d_instr,
    input  logic [n-1:0] d_pcplus,
    output logic [n-1:0] instr,
    output logic [n-1:0] pcplus,
    output logic         valid
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr  <= n'(INSTR_NOP);
            pcplus <= '0;
            valid  <= 1'b0;
        end else if (flush) begin
            instr <= n'(INSTR_NOP);
            valid <= 1'b0;
        end else if (load) begin
            instr  <= d_instr;
            pcplus <= d_pcplus;
            valid  <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, BOOT/RUN/HALT control and next-PC mux feeding ifid_reg.
// Optional perf counters are enabled by defining FETCH_PERF_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int           n        = 16,
    parameter logic [n-1:0] RESET_PC = '0,
    parameter int           PC_STEP  = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic [n-1:0] imem_addr,
    input  logic [n-1:0] imem_rdata,
    input  logic         stall,
    input  logic         redirect,
    input  logic [n-1:0] redirect_pc,
    input  logic         halt,
    output logic [n-1:0] pc,
    output logic [n-1:0] ifid_instr,
    output logic [n-1:0] ifid_pcplus,
    output logic         ifid_valid,
    output logic [2:0]   op,
    output logic         halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stalls
`endif
);
    localparam logic [n-1:0] STEP  = n'(PC_STEP);
    localparam logic [n-1:0] ALIGN = ~n'(1);

    fetch_state_t state, state_next;
    logic [n-1:0] pc_next, pcplus;
    logic         load, flush, reg_valid;

    assign pcplus = pc + STEP;

    // redirect wins over stall; halt stops fetching but still honours a same-edge redirect
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        flush      = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                flush      = redirect | (halt & ~stall);
                load       = ~redirect & ~stall & ~halt;
                pc_next    = redirect ? (redirect_pc & ALIGN) : load ? pcplus : pc;
                state_next = halt ? HALT : RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    ifid_reg #(.n(n)) u_ifid (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .flush    (flush),
        .d_instr  (imem_rdata),
        .d_pcplus (pcplus),
        .instr    (ifid_instr),
        .pcplus   (ifid_pcplus),
        .valid    (reg_valid)
    );

    assign imem_addr  = pc;
    assign halted     = (state == HALT);
    assign ifid_valid = reg_valid & ~halted;
    assign op         = ifid_instr[OP_MSB:OP_LSB];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (load && ~&perf_fetched)
                perf_fetched <= perf_fetched + 32'd1;
            if (state == RUN && stall && !redirect && ~&perf_stalls)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif
endmodule
